// File: rtl/blend_layer_select_pkg.sv
// rtl/blend_layer_select_pkg.sv - shared graphics types for layer selection
//
// Purpose: layer-descriptor bit positions, the select FSM state enum, the
// backdrop rank, the scan candidate struct and a descriptor builder.
// Ports: none (package).

package blend_layer_select_pkg;

    // Layer descriptor layout (20 bits, unlisted bits are always zero)
    localparam int DESC_W            = 20;
    localparam int DESC_BG_LSB       = 8;   // [9:8]   BG index
    localparam int DESC_PRIO_LSB     = 10;  // [11:10] priority
    localparam int DESC_OBJ_BIT      = 12;  // OBJ layer
    localparam int DESC_SEMI_BIT     = 13;  // semi-transparent OBJ
    localparam int DESC_BACKDROP_BIT = 17;  // backdrop

    localparam logic [DESC_W-1:0] BACKDROP_DESC = DESC_W'(1) << DESC_BACKDROP_BIT;

    // Backdrop sits below every real priority (0..3)
    localparam logic [2:0] BACKDROP_RANK = 3'd4;

    // Scan index of the last candidate (OBJ, BG0..BG3)
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] color;
        logic [1:0]  prio;
        logic        visible;
        logic        is_obj;
        logic [1:0]  bg_idx;
        logic        semi;
    } candidate_t;

    // The semi flag only ever reaches a descriptor through an OBJ candidate,
    // so it appears on an output only when OBJ occupies that layer.
    function automatic logic [DESC_W-1:0] make_desc(input candidate_t c);
        logic [DESC_W-1:0] d;
        d = '0;
        d[DESC_BG_LSB +: 2]   = c.bg_idx;
        d[DESC_PRIO_LSB +: 2] = c.prio;
        d[DESC_OBJ_BIT]       = c.is_obj;
        d[DESC_SEMI_BIT]      = c.is_obj & c.semi;
        return d;
    endfunction

endpackage

// File: rtl/blend_layer_select_rank_insert.sv
// rtl/blend_layer_select_rank_insert.sv - combinational compare-and-insert of one candidate
//
// Purpose: insert one candidate into the (top, second) pair by rank.
// Ports:
//   i_cand                         candidate being examined
//   i_top_* / i_sec_*              current top and second (rank, descriptor, colour)
//   o_top_* / o_sec_*              updated top and second

module layer_rank_insert
    import blend_layer_select_pkg::*;
(
    input  candidate_t          i_cand,
    input  logic [2:0]          i_top_rank,
    input  logic [DESC_W-1:0]   i_top_desc,
    input  logic [15:0]         i_top_color,
    input  logic [2:0]          i_sec_rank,
    input  logic [DESC_W-1:0]   i_sec_desc,
    input  logic [15:0]         i_sec_color,
    output logic [2:0]          o_top_rank,
    output logic [DESC_W-1:0]   o_top_desc,
    output logic [15:0]         o_top_color,
    output logic [2:0]          o_sec_rank,
    output logic [DESC_W-1:0]   o_sec_desc,
    output logic [15:0]         o_sec_color
);

    logic [2:0] w_rank;
    logic       w_beats_top;
    logic       w_beats_sec;

    always_comb begin
        w_rank      = {1'b0, i_cand.prio};
        // Strict less-than: equal rank never displaces, so scan order breaks ties
        w_beats_top = i_cand.visible && (w_rank < i_top_rank);
        w_beats_sec = i_cand.visible && (w_rank < i_sec_rank);

        o_top_rank  = i_top_rank;
        o_top_desc  = i_top_desc;
        o_top_color = i_top_color;
        o_sec_rank  = i_sec_rank;
        o_sec_desc  = i_sec_desc;
        o_sec_color = i_sec_color;

        if (w_beats_top) begin
            o_sec_rank  = i_top_rank;
            o_sec_desc  = i_top_desc;
            o_sec_color = i_top_color;
            o_top_rank  = w_rank;
            o_top_desc  = make_desc(i_cand);
            o_top_color = i_cand.color;
        end else if (w_beats_sec) begin
            o_sec_rank  = w_rank;
            o_sec_desc  = make_desc(i_cand);
            o_sec_color = i_cand.color;
        end
    end

endmodule

// File: rtl/blend_layer_select.sv
// rtl/blend_layer_select.sv - sequential top/second layer selection for one pixel
//
// Purpose: accept one pixel's OBJ and BG candidates, scan them one per cycle
// in order OBJ, BG0..BG3, and present the top two layers until taken.
// Ports:
//   clock, reset_n             rising-edge clock, synchronous active-low reset
//   in_valid / in_ready        pixel request handshake
//   bg_color/bg_prio/bg_transp per-BG pixel data
//   layer_en                   [3:0] BG enables, [4] OBJ enable
//   obj_color/obj_prio/obj_transp/obj_semi   OBJ pixel data
//   backdrop                   palette entry 0 colour
//   out_valid / out_ready      result handshake
//   layer0/color0              top layer descriptor and colour
//   layer1/color1              second layer descriptor and colour

module blend_layer_select
    import blend_layer_select_pkg::*;
#(
    parameter int NUM_BG = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         bg_color [NUM_BG],
    input  logic [1:0]          bg_prio  [NUM_BG],
    input  logic [NUM_BG-1:0]   bg_transp,
    input  logic [NUM_BG:0]     layer_en,
    input  logic [15:0]         obj_color,
    input  logic [1:0]          obj_prio,
    input  logic                obj_transp,
    input  logic                obj_semi,
    input  logic [15:0]         backdrop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DESC_W-1:0]   layer0,
    output logic [DESC_W-1:0]   layer1,
    output logic [15:0]         color0,
    output logic [15:0]         color1
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_idx;
    candidate_t         r_cand [NUM_BG+1];
    candidate_t         w_cand_in [NUM_BG+1];
    candidate_t         w_cur;
    logic               w_accept;

    logic [2:0]         r_top_rank;
    logic [DESC_W-1:0]  r_top_desc;
    logic [15:0]        r_top_color;
    logic [2:0]         r_sec_rank;
    logic [DESC_W-1:0]  r_sec_desc;
    logic [15:0]        r_sec_color;

    logic [2:0]         w_top_rank;
    logic [DESC_W-1:0]  w_top_desc;
    logic [15:0]        w_top_color;
    logic [2:0]         w_sec_rank;
    logic [DESC_W-1:0]  w_sec_desc;
    logic [15:0]        w_sec_color;

    logic [DESC_W-1:0]  r_layer0;
    logic [DESC_W-1:0]  r_layer1;
    logic [15:0]        r_color0;
    logic [15:0]        r_color1;

    // Candidate slot 0 is OBJ, slots 1..NUM_BG are BG0..BG(NUM_BG-1)
    always_comb begin
        w_cand_in[0].color   = obj_color;
        w_cand_in[0].prio    = obj_prio;
        w_cand_in[0].visible = layer_en[NUM_BG] & ~obj_transp;
        w_cand_in[0].is_obj  = 1'b1;
        w_cand_in[0].bg_idx  = 2'd0;
        w_cand_in[0].semi    = obj_semi;
        for (int i = 0; i < NUM_BG; i++) begin
            w_cand_in[i+1].color   = bg_color[i];
            w_cand_in[i+1].prio    = bg_prio[i];
            w_cand_in[i+1].visible = layer_en[i] & ~bg_transp[i];
            w_cand_in[i+1].is_obj  = 1'b0;
            w_cand_in[i+1].bg_idx  = 2'(i);
            w_cand_in[i+1].semi    = 1'b0;
        end
    end

    always_comb begin
        w_cur = '0;
        if (r_idx <= LAST_IDX) begin
            w_cur = r_cand[r_idx];
        end
    end

    layer_rank_insert u_insert (
        .i_cand      (w_cur),
        .i_top_rank  (r_top_rank),
        .i_top_desc  (r_top_desc),
        .i_top_color (r_top_color),
        .i_sec_rank  (r_sec_rank),
        .i_sec_desc  (r_sec_desc),
        .i_sec_color (r_sec_color),
        .o_top_rank  (w_top_rank),
        .o_top_desc  (w_top_desc),
        .o_top_color (w_top_color),
        .o_sec_rank  (w_sec_rank),
        .o_sec_desc  (w_sec_desc),
        .o_sec_color (w_sec_color)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)             w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_idx == LAST_IDX)    w_state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready)            w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready is also held low while reset is asserted
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && reset_n;
        out_valid = (r_state == ST_HOLD);
        w_accept  = in_valid && in_ready;
    end

    // Datapath: capture, scan and result registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_idx       <= 3'd0;
            r_top_rank  <= BACKDROP_RANK;
            r_top_desc  <= '0;
            r_top_color <= '0;
            r_sec_rank  <= BACKDROP_RANK;
            r_sec_desc  <= '0;
            r_sec_color <= '0;
            r_layer0    <= '0;
            r_layer1    <= '0;
            r_color0    <= '0;
            r_color1    <= '0;
            for (int i = 0; i <= NUM_BG; i++) begin
                r_cand[i] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i <= NUM_BG; i++) begin
                            r_cand[i] <= w_cand_in[i];
                        end
                        // Both slots start as backdrop so any visible layer displaces them
                        r_idx       <= 3'd0;
                        r_top_rank  <= BACKDROP_RANK;
                        r_top_desc  <= BACKDROP_DESC;
                        r_top_color <= backdrop;
                        r_sec_rank  <= BACKDROP_RANK;
                        r_sec_desc  <= BACKDROP_DESC;
                        r_sec_color <= backdrop;
                    end
                end
                ST_SCAN: begin
                    r_top_rank  <= w_top_rank;
                    r_top_desc  <= w_top_desc;
                    r_top_color <= w_top_color;
                    r_sec_rank  <= w_sec_rank;
                    r_sec_desc  <= w_sec_desc;
                    r_sec_color <= w_sec_color;
                    if (r_idx == LAST_IDX) begin
                        // Last candidate folds straight into the held result
                        r_idx    <= 3'd0;
                        r_layer0 <= w_top_desc;
                        r_color0 <= w_top_color;
                        r_layer1 <= w_sec_desc;
                        r_color1 <= w_sec_color;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign layer0 = r_layer0;
    assign layer1 = r_layer1;
    assign color0 = r_color0;
    assign color1 = r_color1;

endmodule

// File: tb/tb_blend_layer_select.sv
// tb/tb_blend_layer_select.sv - scoreboard bench for blend_layer_select

module tb_blend_layer_select;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bg_color [4];
    logic [1:0]  bg_prio [4];
    logic [3:0]  bg_transp;
    logic [4:0]  layer_en;
    logic [15:0] obj_color;
    logic [1:0]  obj_prio;
    logic        obj_transp;
    logic        obj_semi;
    logic [15:0] backdrop;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] layer0, layer1;
    logic [15:0] color0, color1;

    blend_layer_select #(.NUM_BG(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bg_color   (bg_color),
        .bg_prio    (bg_prio),
        .bg_transp  (bg_transp),
        .layer_en   (layer_en),
        .obj_color  (obj_color),
        .obj_prio   (obj_prio),
        .obj_transp (obj_transp),
        .obj_semi   (obj_semi),
        .backdrop   (backdrop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .layer0     (layer0),
        .layer1     (layer1),
        .color0     (color0),
        .color1     (color1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] l0;
        logic [19:0] l1;
        logic [15:0] c0;
        logic [15:0] c1;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] c3, input logic [15:0] c2,
                        input logic [15:0] c1, input logic [15:0] c0,
                        input logic [1:0] p3, input logic [1:0] p2,
                        input logic [1:0] p1, input logic [1:0] p0,
                        input logic [3:0] tr, input logic [4:0] en,
                        input logic [15:0] oc, input logic [1:0] op,
                        input logic ot, input logic os, input logic [15:0] bd);
        bg_color[0] = c0; bg_color[1] = c1; bg_color[2] = c2; bg_color[3] = c3;
        bg_prio[0]  = p0; bg_prio[1]  = p1; bg_prio[2]  = p2; bg_prio[3]  = p3;
        bg_transp  = tr;
        layer_en   = en;
        obj_color  = oc;
        obj_prio   = op;
        obj_transp = ot;
        obj_semi   = os;
        backdrop   = bd;
    endtask

    // Waits for in_ready, performs one accept, and records the expected result
    task automatic send(input logic push, input logic [19:0] l0, input logic [19:0] l1,
                        input logic [15:0] c0, input logic [15:0] c1);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        last_acc = cyc;
        if (push) sb.push_back('{l0, l1, c0, c1, cyc});
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: samples just after the falling edge, after any stimulus change
    exp_t mon_e;
    int   rise_cyc = 0;
    logic prev_v = 1'b0;
    always begin
        @(negedge clock);
        #1;
        if (out_valid && !prev_v) rise_cyc = cyc;
        prev_v = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("layer0", layer0, mon_e.l0);
                chk("layer1", layer1, mon_e.l1);
                chk("color0", color0, mon_e.c0);
                chk("color1", color1, mon_e.c1);
                // cycle 1 is the cycle right after the accept edge
                chk("latency", rise_cyc - mon_e.acc + 1, 6);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc1;
        int seen;
        int guard;

        load(16'h0, 16'h0, 16'h0, 16'h0, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0, 5'h00,
             16'h0, 2'd0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_layer0", layer0, 0);
        chk("rst_layer1", layer1, 0);
        chk("rst_color0", color0, 0);
        chk("rst_color1", color1, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_in_ready", in_ready, 1);

        // V1: all visible, BG prios {3,2,1,0}, OBJ prio 2 -> BG3 top, BG2 second
        load(16'h0004, 16'h0003, 16'h0002, 16'h0001, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0000, 5'h1F,
             16'h0010, 2'd2, 1'b0, 1'b0, 16'h1234);
        send(1'b1, 20'h00300, 20'h00600, 16'h0004, 16'h0003);
        acc1 = last_acc;

        // V2: OBJ prio 1 ties BG1 prio 1, semi OBJ wins the tie
        load(16'h0444, 16'h0333, 16'h0BB0, 16'h0111, 2'd0, 2'd0, 2'd1, 2'd0, 4'b1101, 5'h1F,
             16'h00AA, 2'd1, 1'b0, 1'b1, 16'h1234);
        send(1'b1, 20'h03400, 20'h00500, 16'h00AA, 16'h0BB0);
        chk("throughput", last_acc - acc1, 7);

        // V3: nothing enabled -> backdrop on both layers, no semi bit
        load(16'h0444, 16'h0333, 16'h0222, 16'h0111, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 5'h00,
             16'h0EEE, 2'd0, 1'b0, 1'b1, 16'h5555);
        send(1'b1, 20'h20000, 20'h20000, 16'h5555, 16'h5555);

        // V4: only BG2 visible -> second is backdrop
        load(16'h0444, 16'h7C1F, 16'h0222, 16'h0111, 2'd0, 2'd3, 2'd0, 2'd0, 4'b1011, 5'h0F,
             16'h0EEE, 2'd0, 1'b0, 1'b0, 16'h0421);
        send(1'b1, 20'h00E00, 20'h20000, 16'h7C1F, 16'h0421);

        // V5: BG0/BG1/BG2 tie at prio 2, OBJ disabled though opaque at prio 0
        load(16'h4444, 16'h3333, 16'h2222, 16'h1111, 2'd0, 2'd2, 2'd2, 2'd2, 4'b1000, 5'h0F,
             16'h0EEE, 2'd0, 1'b0, 1'b0, 16'h0000);
        send(1'b1, 20'h00800, 20'h00900, 16'h1111, 16'h2222);
        wait_drain();

        // V6: held result under back-pressure, new requests ignored
        out_ready = 1'b0;
        load(16'h0004, 16'h0003, 16'h0002, 16'h0001, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0000, 5'h1F,
             16'h0010, 2'd2, 1'b0, 1'b0, 16'h1234);
        send(1'b1, 20'h00300, 20'h00600, 16'h0004, 16'h0003);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("hold_reached", out_valid, 1);
        load(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 5'h1F,
             16'h0B0B, 2'd0, 1'b0, 1'b1, 16'h0A0A);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_layer0", layer0, 20'h00300);
            chk("stall_color1", color1, 16'h0003);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("release_in_ready", in_ready, 1);
        wait_drain();

        // V7: reset while scanning index 2 aborts with no output
        load(16'h0004, 16'h0003, 16'h0002, 16'h0001, 2'd0, 2'd1, 2'd2, 2'd3, 4'b0000, 5'h1F,
             16'h0010, 2'd2, 1'b0, 1'b0, 16'h1234);
        send(1'b0, 20'h0, 20'h0, 16'h0, 16'h0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_layer0", layer0, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_rel_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        chk("abort_no_output", seen, 0);

        // V8: normal operation after the abort
        load(16'h0444, 16'h7C1F, 16'h0222, 16'h0111, 2'd0, 2'd3, 2'd0, 2'd0, 4'b1011, 5'h0F,
             16'h0EEE, 2'd0, 1'b0, 1'b0, 16'h0421);
        send(1'b1, 20'h00E00, 20'h20000, 16'h7C1F, 16'h0421);
        wait_drain();
        repeat (3) @(negedge clock);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
